demux_sched: RTL and testbench

- Scheduler and sequencer for the 1-to-4 demultiplexer datapath.
- Accepts a single valid/ready input stream and holds each beat in a one-entry buffer.
- Drives the demux select lines and per-channel valid to route the buffered beat to one of four outputs.
- Channel choice is either addressed (per-beat destination) or round-robin with a burst limit; a stall timeout protects against a hung consumer.

---
 rtl/demux_pkg.sv | 18 +
 rtl/demux_rr_pick.sv | 28 ++
 rtl/demux_sched.sv | 118 +++++++++++
 tb/tb_demux_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 demux scheduler.
// Channel index, FSM state and one-hot helper.
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot4(input ch_idx_t idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Next-enabled-channel search, upward mod 4 from i_ptr.
// Ports: i_ptr, i_en in; o_tgt, o_none out.
import demux_pkg::*;

module demux_rr_pick (
  input  ch_idx_t            i_ptr,
  input  logic [NUM_CH-1:0]  i_en,
  output ch_idx_t            o_tgt,
  output logic               o_none
);

  ch_idx_t w_idx;

  // Walk offsets high to low so the nearest enabled channel wins.
  always_comb begin
    o_tgt  = i_ptr;
    o_none = 1'b1;
    w_idx  = i_ptr;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      w_idx = i_ptr + ch_idx_t'(k);
      if (i_en[w_idx]) begin
        o_tgt  = w_idx;
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_sched.sv
// One-entry buffered scheduler driving a 1-to-4 demux.
// Ports: in_* stream, mode/ch_en control, sel/out_* to demux, drop_err, busy.
import demux_pkg::*;

module demux_sched #(
  parameter int DW      = 8,
  parameter int BURST   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [1:0]        in_dest,
  input  logic              mode,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [1:0]        sel,
  output logic [DW-1:0]     out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic              drop_err,
  output logic              busy
);

  localparam logic [3:0] BURST_C  = 4'(BURST);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT-1);

  state_t            r_state;
  ch_idx_t           r_sel;
  ch_idx_t           r_ptr;
  logic [DW-1:0]     r_data;
  logic [NUM_CH-1:0] r_oval;
  logic [3:0]        r_bcnt;
  logic [7:0]        r_tcnt;
  logic              r_drop;

  ch_idx_t    w_rr_tgt;
  logic       w_none;
  ch_idx_t    w_tgt;
  logic       w_fwd;
  logic       w_fire;
  logic       w_tmo;
  logic       w_acc;
  logic [3:0] w_bnext;

  demux_rr_pick u_pick (
    .i_ptr  (r_ptr),
    .i_en   (ch_en),
    .o_tgt  (w_rr_tgt),
    .o_none (w_none)
  );

  assign w_fire = |(r_oval & out_ready);
  assign w_tmo  = (r_state == FULL) && !w_fire
                && (r_tcnt == TMO_LAST);

  always_comb begin
    in_ready = 1'b0;
    unique case (r_state)
      EMPTY:   in_ready = ~(mode & w_none);
      FULL:    in_ready = w_fire;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_acc = in_valid & in_ready;
  assign w_tgt = mode ? w_rr_tgt : in_dest;
  assign w_fwd = mode ? ~w_none : ch_en[in_dest];

  // A jump away from ptr starts a fresh burst.
  assign w_bnext = ((w_rr_tgt != r_ptr) ? 4'd0 : r_bcnt)
                 + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_oval  <= '0;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= (w_acc & ~w_fwd) | w_tmo;
      if (w_acc & w_fwd & mode) begin
        if (w_bnext == BURST_C) begin
          r_bcnt <= '0;
          r_ptr  <= w_rr_tgt + 2'd1;
        end else begin
          r_bcnt <= w_bnext;
          r_ptr  <= w_rr_tgt;
        end
      end
      if (w_acc & w_fwd) begin
        r_state <= FULL;
        r_sel   <= w_tgt;
        r_data  <= in_data;
        r_oval  <= onehot4(w_tgt);
        r_tcnt  <= '0;
      end else if (w_fire | w_tmo) begin
        r_state <= EMPTY;
        r_oval  <= '0;
        r_tcnt  <= '0;
      end else if (r_state == FULL) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
    end
  end

  assign sel       = r_sel;
  assign out_data  = r_data;
  assign out_valid = r_oval;
  assign drop_err  = r_drop;
  assign busy      = (r_state == FULL);

endmodule

// File: tb/tb_demux_sched.sv
// Randomized self-checking bench for demux_sched.
// Reference model tracks the buffered beat and round-robin rules.
module tb_demux_sched;

  localparam int DW      = 8;
  localparam int BURST   = 2;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_dest = '0;
  logic          mode = 1'b0;
  logic [3:0]    ch_en = 4'hF;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'hF;
  logic          drop_err;
  logic          busy;

  always #5 clk = ~clk;

  demux_sched #(
    .DW(DW), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest),
    .mode(mode), .ch_en(ch_en),
    .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .drop_err(drop_err), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending beat, its age in FULL cycles, rr position.
  bit m_full;
  int m_ch, m_sel, m_data, m_age, m_ptr, m_run;
  bit m_drop;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_ch = 0; m_sel = 0; m_data = 0;
    m_age = 0; m_ptr = 0; m_run = 0; m_drop = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic [1:0] dst, input logic md,
                      input logic [3:0] en, input logic [3:0] rdy);
    bit fire, tmo, erdy, acc, ok;
    int tgt;
    @(negedge clk);
    in_valid = v; in_data = d; in_dest = dst;
    mode = md; ch_en = en; out_ready = rdy;
    #1;
    fire = m_full && rdy[m_ch];
    tmo  = m_full && !fire && (m_age == TIMEOUT);
    erdy = m_full ? fire : !(md && en == 4'h0);
    chk("in_ready", 32'(in_ready), 32'(erdy));
    chk("busy", 32'(busy), 32'(m_full));
    chk("out_valid", 32'(out_valid),
        m_full ? (32'd1 << m_ch) : 32'd0);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("drop_err", 32'(drop_err), 32'(m_drop));
    acc = v && erdy;
    ok = 0;
    tgt = 0;
    if (acc) begin
      if (!md) begin
        tgt = dst;
        ok = en[dst];
      end else begin
        for (int c = 3; c >= 0; c--) begin
          if (en[(m_ptr + c) % 4]) begin
            tgt = (m_ptr + c) % 4;
            ok = 1;
          end
        end
        if (ok) begin
          if (tgt != m_ptr) m_run = 0;
          m_run++;
          if (m_run == BURST) begin
            m_run = 0;
            m_ptr = (tgt + 1) % 4;
          end else begin
            m_ptr = tgt;
          end
        end
      end
    end
    m_drop = (acc && !ok) || tmo;
    if (acc && ok) begin
      m_full = 1; m_ch = tgt; m_sel = tgt;
      m_data = d; m_age = 1;
    end else if (fire || tmo) begin
      m_full = 0;
    end else if (m_full) begin
      m_age++;
    end
  endtask

  task automatic idle(input int n, input logic [3:0] rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'hF, rdy);
  endtask

  int stall;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    rst = 1'b0;
    idle(1, 4'hF);

    // Addressed routing, back-to-back.
    step(1, 8'h11, 2'd0, 0, 4'hF, 4'hF);
    step(1, 8'h22, 2'd1, 0, 4'hF, 4'hF);
    step(1, 8'h33, 2'd2, 0, 4'hF, 4'hF);
    step(1, 8'h44, 2'd3, 0, 4'hF, 4'hF);
    idle(2, 4'hF);

    // Round-robin burst with wrap.
    for (int i = 0; i < 10; i++)
      step(1, 8'(8'h50 + i), 2'd0, 1, 4'hF, 4'hF);
    idle(1, 4'hF);

    // Skip disabled channels, then addressed drop.
    for (int i = 0; i < 4; i++)
      step(1, 8'(8'h60 + i), 2'd0, 1, 4'b1010, 4'hF);
    step(1, 8'h70, 2'd0, 0, 4'b1010, 4'hF);
    idle(2, 4'hF);
    step(1, 8'h71, 2'd0, 1, 4'h0, 4'hF);

    // Backpressure on ch2, then release with a new beat.
    step(1, 8'h80, 2'd2, 0, 4'hF, 4'b1011);
    for (int i = 0; i < 5; i++)
      step(1, 8'h81, 2'd1, 0, 4'hF, 4'b1011);
    step(1, 8'h81, 2'd1, 0, 4'hF, 4'hF);
    idle(2, 4'hF);

    // Timeout drop, then fire on the last allowed cycle.
    step(1, 8'h90, 2'd2, 0, 4'hF, 4'h0);
    idle(TIMEOUT + 2, 4'h0);
    step(1, 8'h91, 2'd3, 0, 4'hF, 4'h0);
    idle(TIMEOUT - 1, 4'h0);
    idle(3, 4'hF);

    // Async reset while FULL mid-burst.
    step(1, 8'hA0, 2'd0, 1, 4'hF, 4'hF);
    step(1, 8'hA1, 2'd0, 1, 4'hF, 4'hF);
    step(1, 8'hA2, 2'd0, 1, 4'hF, 4'h0);
    step(0, 8'h00, 2'd0, 1, 4'hF, 4'h0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_oval", 32'(out_valid), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_drop", 32'(drop_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1, 8'(8'hB0 + i), 2'd0, 1, 4'hF, 4'hF);
    idle(1, 4'hF);

    // Randomized traffic with occasional long stalls.
    stall = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] en, rdy;
      if (i % 150 == 100) stall = $urandom_range(10, 22);
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (stall > 0) begin
        rdy = 4'h0;
        stall--;
      end else begin
        rdy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      end
      step(1'($urandom_range(0, 3) != 0), 8'($urandom),
           2'($urandom), 1'($urandom), en, rdy);
    end
    idle(2, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
